id_ex_skid_stage: RTL and testbench

- Parametrised decode-to-execute pipeline stage for the RISC-V pipeline core.
- Replaces the single hold-on-wait register with a 2-entry valid/ready skid buffer.
- Carries NSRC operand channels, each sourced from the integer or FP register file, plus PC, PC+4, immediate, rd and a packed control word.
- Adds a synchronous flush, and a writeback refresh that keeps held operands current while the stage is stalled.

---
 rtl/id_ex_skid_stage_if.sv | 53 +++++
 rtl/id_ex_skid_stage.sv | 152 +++++++++++++++
 tb/tb_id_ex_skid_stage.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_skid_stage_if.sv
// Decode-to-execute stage bus: decode side, writeback refresh,
// flush, execute side and occupancy. The slave modport is the stage's view.
interface id_ex_skid_stage_if #(
   parameter int XLEN   = 32,
   parameter int NSRC   = 2,
   parameter int CTRL_W = 16,
   parameter int REGA_W = 5
);
   // decode side
   logic                   in_valid;
   logic                   in_ready;
   logic [CTRL_W-1:0]      in_ctrl;
   logic [XLEN-1:0]        in_pc;
   logic [XLEN-1:0]        in_pc4;
   logic [XLEN-1:0]        in_imm;
   logic [REGA_W-1:0]      in_rd;
   logic [NSRC*REGA_W-1:0] in_rs;
   logic [NSRC-1:0]        in_src_fp;
   logic [NSRC*XLEN-1:0]   in_opd;
   // writeback refresh
   logic                   wb_en;
   logic                   wb_fp;
   logic [REGA_W-1:0]      wb_rd;
   logic [XLEN-1:0]        wb_data;
   // kill
   logic                   flush;
   // execute side
   logic                   out_valid;
   logic                   out_ready;
   logic [CTRL_W-1:0]      out_ctrl;
   logic [XLEN-1:0]        out_pc;
   logic [XLEN-1:0]        out_pc4;
   logic [XLEN-1:0]        out_imm;
   logic [REGA_W-1:0]      out_rd;
   logic [NSRC*REGA_W-1:0] out_rs;
   logic [NSRC-1:0]        out_src_fp;
   logic [NSRC*XLEN-1:0]   out_opd;
   logic [1:0]             occupancy;

   modport slave (
      input  in_valid, in_ctrl, in_pc, in_pc4, in_imm, in_rd, in_rs, in_src_fp, in_opd,
      input  wb_en, wb_fp, wb_rd, wb_data, flush, out_ready,
      output in_ready, out_valid, out_ctrl, out_pc, out_pc4, out_imm, out_rd,
      output out_rs, out_src_fp, out_opd, occupancy
   );

   modport master (
      output in_valid, in_ctrl, in_pc, in_pc4, in_imm, in_rd, in_rs, in_src_fp, in_opd,
      output wb_en, wb_fp, wb_rd, wb_data, flush, out_ready,
      input  in_ready, out_valid, out_ctrl, out_pc, out_pc4, out_imm, out_rd,
      input  out_rs, out_src_fp, out_opd, occupancy
   );
endinterface

// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline stage as a 2-entry valid/ready skid buffer (main drives the
// outputs, skid holds the overflow). Held operands are refreshed from the
// writeback port so a stalled instruction never carries a stale source value.

// One operand channel: replace the operand when the writeback hits this source.
// Integer x0 is hardwired zero and never refreshed; FP f0 is a real register.
module id_ex_opd_fwd #(
   parameter int XLEN   = 32,
   parameter int REGA_W = 5
) (
   input  logic              en,
   input  logic [REGA_W-1:0] rs,
   input  logic              src_fp,
   input  logic [XLEN-1:0]   opd,
   input  logic              wb_en,
   input  logic              wb_fp,
   input  logic [REGA_W-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic [XLEN-1:0]   opd_o
);
   logic hit;
   assign hit   = en & wb_en & (wb_rd == rs) & (wb_fp == src_fp) & (wb_fp | (wb_rd != '0));
   assign opd_o = hit ? wb_data : opd;
endmodule

module id_ex_skid_stage #(
   parameter int XLEN   = 32,
   parameter int NSRC   = 2,
   parameter int CTRL_W = 16,
   parameter int REGA_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   id_ex_skid_stage_if.slave    bus
);
   typedef struct packed {
      logic [CTRL_W-1:0]           ctrl;
      logic [XLEN-1:0]             pc;
      logic [XLEN-1:0]             pc4;
      logic [XLEN-1:0]             imm;
      logic [REGA_W-1:0]           rd;
      logic [NSRC-1:0][REGA_W-1:0] rs;
      logic [NSRC-1:0]             src_fp;
      logic [NSRC-1:0][XLEN-1:0]   opd;
   } ent_t;

   ent_t main_q, main_d, skid_q, skid_d, in_ent;
   logic main_v_q, main_v_d, skid_v_q, skid_v_d;
   logic accept, pop;

   logic [NSRC-1:0][REGA_W-1:0] in_rs;
   logic [NSRC-1:0][XLEN-1:0]   in_opd, in_opd_r, main_opd_r, skid_opd_r;

   assign in_rs  = bus.in_rs;
   assign in_opd = bus.in_opd;

   // in_ready comes from state only, so out_ready never reaches it combinationally
   assign bus.in_ready = !skid_v_q;
   assign accept       = bus.in_valid & !skid_v_q;
   assign pop          = main_v_q & bus.out_ready;

   // Refresh the incoming instruction and both held entries, channel by channel
   for (genvar i = 0; i < NSRC; i++) begin : g_ch
      id_ex_opd_fwd #(.XLEN(XLEN), .REGA_W(REGA_W)) u_fwd_in (
         .en(1'b1), .rs(in_rs[i]), .src_fp(bus.in_src_fp[i]), .opd(in_opd[i]),
         .wb_en(bus.wb_en), .wb_fp(bus.wb_fp), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
         .opd_o(in_opd_r[i])
      );
      id_ex_opd_fwd #(.XLEN(XLEN), .REGA_W(REGA_W)) u_fwd_main (
         .en(main_v_q), .rs(main_q.rs[i]), .src_fp(main_q.src_fp[i]), .opd(main_q.opd[i]),
         .wb_en(bus.wb_en), .wb_fp(bus.wb_fp), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
         .opd_o(main_opd_r[i])
      );
      id_ex_opd_fwd #(.XLEN(XLEN), .REGA_W(REGA_W)) u_fwd_skid (
         .en(skid_v_q), .rs(skid_q.rs[i]), .src_fp(skid_q.src_fp[i]), .opd(skid_q.opd[i]),
         .wb_en(bus.wb_en), .wb_fp(bus.wb_fp), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
         .opd_o(skid_opd_r[i])
      );
   end

   // Next-state: FIFO-ordered move between input, skid and main; flush wins
   always_comb begin
      in_ent        = '0;
      in_ent.ctrl   = bus.in_ctrl;
      in_ent.pc     = bus.in_pc;
      in_ent.pc4    = bus.in_pc4;
      in_ent.imm    = bus.in_imm;
      in_ent.rd     = bus.in_rd;
      in_ent.rs     = in_rs;
      in_ent.src_fp = bus.in_src_fp;
      in_ent.opd    = in_opd_r;

      main_d      = main_q;
      main_d.opd  = main_opd_r;
      skid_d      = skid_q;
      skid_d.opd  = skid_opd_r;
      main_v_d    = main_v_q;
      skid_v_d    = skid_v_q;

      if (!main_v_q) begin
         if (accept) begin
            main_d   = in_ent;
            main_v_d = 1'b1;
         end
      end else if (!skid_v_q) begin
         if (accept && pop) begin
            main_d = in_ent;
         end else if (accept) begin
            skid_d   = in_ent;
            skid_v_d = 1'b1;
         end else if (pop) begin
            main_v_d = 1'b0;
         end
      end else if (pop) begin
         // skid already carries its refreshed operands
         main_d      = skid_q;
         main_d.opd  = skid_opd_r;
         skid_v_d    = 1'b0;
      end

      if (bus.flush) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end
   end

   // Stage registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
      end else begin
         main_q   <= main_d;
         skid_q   <= skid_d;
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
      end
   end

   assign bus.out_valid  = main_v_q;
   assign bus.out_ctrl   = main_v_q ? main_q.ctrl : '0;
   assign bus.out_pc     = main_q.pc;
   assign bus.out_pc4    = main_q.pc4;
   assign bus.out_imm    = main_q.imm;
   assign bus.out_rd     = main_q.rd;
   assign bus.out_rs     = main_q.rs;
   assign bus.out_src_fp = main_q.src_fp;
   assign bus.out_opd    = main_q.opd;
   assign bus.occupancy  = 2'(main_v_q) + 2'(skid_v_q);
endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Directed bench for id_ex_skid_stage: handshake, back-pressure, streaming,
// writeback refresh, flush and asynchronous reset.
module tb_id_ex_skid_stage;
   localparam int XLEN = 32, NSRC = 2, CTRL_W = 16, REGA_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_chk = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   id_ex_skid_stage_if #(.XLEN(XLEN), .NSRC(NSRC), .CTRL_W(CTRL_W), .REGA_W(REGA_W)) bus ();

   id_ex_skid_stage #(.XLEN(XLEN), .NSRC(NSRC), .CTRL_W(CTRL_W), .REGA_W(REGA_W)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ctrl_of(input logic [31:0] pc);
      return 16'hA000 | {4'h0, pc[11:0]};
   endfunction

   // advance one edge; inputs are changed and outputs sampled 1 time unit later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc,
                        input logic [4:0] rs0, input logic fp0, input logic [31:0] opd0,
                        input logic [4:0] rs1, input logic fp1, input logic [31:0] opd1);
      bus.in_valid  = v;
      bus.in_pc     = pc;
      bus.in_pc4    = pc + 32'd4;
      bus.in_imm    = pc ^ 32'h0000_0F00;
      bus.in_ctrl   = ctrl_of(pc);
      bus.in_rd     = pc[6:2];
      bus.in_rs     = {rs1, rs0};
      bus.in_src_fp = {fp1, fp0};
      bus.in_opd    = {opd1, opd0};
   endtask

   task automatic push(input logic [31:0] pc);
      drive(1'b1, pc, 5'd1, 1'b0, 32'h0, 5'd2, 1'b0, 32'h0);
   endtask

   task automatic wb(input logic en, input logic fp, input logic [4:0] rd, input logic [31:0] d);
      bus.wb_en = en; bus.wb_fp = fp; bus.wb_rd = rd; bus.wb_data = d;
   endtask

   initial begin
      drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
      wb(1'b0, 1'b0, 5'd0, 32'h0);
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;

      // reset state
      #2;
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_ctrl",  64'(bus.out_ctrl),  64'd0);
      chk("rst_occ",   64'(bus.occupancy), 64'd0);
      chk("rst_ready", 64'(bus.in_ready),  64'd1);
      chk("rst_pc",    64'(bus.out_pc),    64'd0);
      chk("rst_opd",   64'(bus.out_opd),   64'd0);
      #10 rst = 1'b1;
      step();

      // back-pressure: three offered, two held
      push(32'h0);
      step();
      chk("bp1_pc",    64'(bus.out_pc),    64'h0);
      chk("bp1_ctrl",  64'(bus.out_ctrl),  64'(ctrl_of(32'h0)));
      chk("bp1_pc4",   64'(bus.out_pc4),   64'h4);
      chk("bp1_occ",   64'(bus.occupancy), 64'd1);
      chk("bp1_ready", 64'(bus.in_ready),  64'd1);
      push(32'h4);
      step();
      chk("bp2_occ",   64'(bus.occupancy), 64'd2);
      chk("bp2_ready", 64'(bus.in_ready),  64'd0);
      chk("bp2_pc",    64'(bus.out_pc),    64'h0);
      push(32'h8);
      step();
      chk("bp3_occ",   64'(bus.occupancy), 64'd2);
      chk("bp3_pc",    64'(bus.out_pc),    64'h0);
      bus.out_ready = 1'b1;
      step();
      chk("bp4_pc",    64'(bus.out_pc),    64'h4);
      chk("bp4_occ",   64'(bus.occupancy), 64'd1);
      chk("bp4_ready", 64'(bus.in_ready),  64'd1);
      step();
      chk("bp5_pc",    64'(bus.out_pc),    64'h8);
      chk("bp5_occ",   64'(bus.occupancy), 64'd1);
      bus.in_valid = 1'b0;
      step();
      chk("bp6_valid", 64'(bus.out_valid), 64'd0);
      chk("bp6_ctrl",  64'(bus.out_ctrl),  64'd0);

      // streaming: one in, one out per cycle
      for (int k = 0; k < 8; k++) begin
         push(32'(k * 4));
         step();
         chk("st_pc",    64'(bus.out_pc),    64'(k * 4));
         chk("st_occ",   64'(bus.occupancy), 64'd1);
         chk("st_ready", 64'(bus.in_ready),  64'd1);
      end
      bus.in_valid = 1'b0;
      step();
      chk("st_drain", 64'(bus.occupancy), 64'd0);

      // stale-operand refresh on a held entry
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h20, 5'd5, 1'b0, 32'h11, 5'd0, 1'b0, 32'h22);
      step();
      chk("rf_opd0", 64'(bus.out_opd[31:0]), 64'h11);
      bus.in_valid = 1'b0;
      wb(1'b1, 1'b0, 5'd5, 32'hDEAD);
      step();
      chk("rf_x5", 64'(bus.out_opd[31:0]), 64'hDEAD);
      wb(1'b1, 1'b1, 5'd5, 32'hBEEF);
      step();
      chk("rf_f5", 64'(bus.out_opd[31:0]), 64'hDEAD);
      wb(1'b1, 1'b0, 5'd0, 32'h1234);
      step();
      chk("rf_x0", 64'(bus.out_opd[63:32]), 64'h22);
      chk("rf_rs",  64'(bus.out_rs),        64'({5'd0, 5'd5}));
      wb(1'b0, 1'b0, 5'd0, 32'h0);
      bus.out_ready = 1'b1;
      step();
      chk("rf_drain", 64'(bus.occupancy), 64'd0);

      // writeback wins over the decode operand at capture
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h30, 5'd3, 1'b0, 32'h33, 5'd9, 1'b1, 32'h44);
      wb(1'b1, 1'b0, 5'd3, 32'h77);
      step();
      chk("cap_opd0", 64'(bus.out_opd[31:0]),  64'h77);
      chk("cap_opd1", 64'(bus.out_opd[63:32]), 64'h44);
      wb(1'b0, 1'b0, 5'd0, 32'h0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();

      // flush with a full stage and an offered instruction
      bus.out_ready = 1'b0;
      push(32'h40);
      step();
      push(32'h44);
      step();
      chk("fl_full", 64'(bus.occupancy), 64'd2);
      push(32'h48);
      bus.flush = 1'b1;
      step();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("fl_valid", 64'(bus.out_valid), 64'd0);
      chk("fl_ctrl",  64'(bus.out_ctrl),  64'd0);
      chk("fl_occ",   64'(bus.occupancy), 64'd0);
      chk("fl_ready", 64'(bus.in_ready),  64'd1);
      step();
      chk("fl_gone", 64'(bus.occupancy), 64'd0);
      // flush discarding a same-cycle accept at occupancy 1
      push(32'h50);
      step();
      push(32'h54);
      bus.flush = 1'b1;
      step();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("fl1_occ", 64'(bus.occupancy), 64'd0);
      step();
      chk("fl1_gone", 64'(bus.out_valid), 64'd0);

      // skid-to-main move picks up an FP writeback
      drive(1'b1, 32'h60, 5'd1, 1'b0, 32'h5, 5'd2, 1'b1, 32'h6);
      step();
      drive(1'b1, 32'h64, 5'd1, 1'b0, 32'h7, 5'd7, 1'b1, 32'h1);
      step();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      wb(1'b1, 1'b1, 5'd7, 32'h3F80_0000);
      step();
      wb(1'b0, 1'b0, 5'd0, 32'h0);
      chk("sk_pc",   64'(bus.out_pc),          64'h64);
      chk("sk_opd1", 64'(bus.out_opd[63:32]),  64'h3F80_0000);
      chk("sk_opd0", 64'(bus.out_opd[31:0]),   64'h7);
      chk("sk_fp",   64'(bus.out_src_fp),      64'b10);
      chk("sk_imm",  64'(bus.out_imm),         64'h0000_0F64);
      step();
      chk("sk_drain", 64'(bus.occupancy), 64'd0);

      // asynchronous reset mid-stream
      bus.out_ready = 1'b0;
      push(32'h70);
      step();
      push(32'h74);
      step();
      chk("ar_full", 64'(bus.occupancy), 64'd2);
      bus.in_valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("ar_valid", 64'(bus.out_valid), 64'd0);
      chk("ar_ctrl",  64'(bus.out_ctrl),  64'd0);
      chk("ar_occ",   64'(bus.occupancy), 64'd0);
      chk("ar_ready", 64'(bus.in_ready),  64'd1);
      chk("ar_pc",    64'(bus.out_pc),    64'd0);
      #1 rst = 1'b1;
      push(32'h100);
      step();
      bus.in_valid = 1'b0;
      chk("ar_pc100", 64'(bus.out_pc),    64'h100);
      chk("ar_v100",  64'(bus.out_valid), 64'd1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
